// File: rtl/cksum_arb_pkg.sv
// cksum_arb_pkg: shared FSM encoding, default parameters and width helper for checksum_arbiter.
package cksum_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COLLECT,
    RESP
  } state_e;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_IN_DATA_WIDTH  = 17;
  localparam int DEF_OUT_DATA_WIDTH = 21;
  localparam int DEF_SEG_COUNT      = 8;
  localparam int DEF_ACC_WIDTH      = 24;
  localparam int DEF_TIMEOUT        = 64;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/checksum_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at or above the pointer, wrapping.
module rr_arbiter
  import cksum_arb_pkg::*;
#(
  parameter int N = DEF_NUM_REQ
) (
  input  logic [N-1:0]              req_i,
  input  logic [id_width(N)-1:0]    ptr_i,
  input  logic                      en_i,
  output logic [N-1:0]              grant_o,
  output logic [id_width(N)-1:0]    idx_o
);

  localparam int IW = id_width(N);

  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (en_i && !found && req_i[(int'(ptr_i) + k) % N]) begin
        found                            = 1'b1;
        grant_o[(int'(ptr_i) + k) % N]   = 1'b1;
        idx_o                            = IW'((int'(ptr_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/checksum_arbiter.sv
// checksum_arbiter: round-robin sharing of one checksum engine; sums SEG_COUNT result beats per job.
// Optional CKSUM_ARB_STATS_EN adds saturating job/timeout counters.
module checksum_arbiter
  import cksum_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int IN_DATA_WIDTH  = DEF_IN_DATA_WIDTH,
  parameter int OUT_DATA_WIDTH = DEF_OUT_DATA_WIDTH,
  parameter int SEG_COUNT      = DEF_SEG_COUNT,
  parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
  parameter int TIMEOUT        = DEF_TIMEOUT
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_vld,
  input  logic [NUM_REQ*IN_DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ*4-1:0]               req_poly,
  output logic [NUM_REQ-1:0]                 req_rdy,
  output logic                               eng_in_data_vld,
  output logic [IN_DATA_WIDTH-1:0]           eng_in_data,
  output logic [3:0]                         eng_polynomial,
  input  logic [OUT_DATA_WIDTH-1:0]          eng_out_data,
  input  logic                               eng_out_data_vld,
  output logic                               rsp_vld,
  output logic [id_width(NUM_REQ)-1:0]       rsp_id,
  output logic [ACC_WIDTH-1:0]               rsp_sum,
  output logic                               rsp_err,
  input  logic                               rsp_rdy,
  output logic                               busy
`ifdef CKSUM_ARB_STATS_EN
  ,
  output logic [15:0]                        stat_jobs,
  output logic [7:0]                         stat_timeouts
`endif
);

  localparam int IW = id_width(NUM_REQ);
  localparam int BW = $clog2(SEG_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e                   state_q, state_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic [IW-1:0]            id_q, id_d;
  logic [IN_DATA_WIDTH-1:0] data_q, data_d;
  logic [3:0]               poly_q, poly_d;
  logic [ACC_WIDTH-1:0]     acc_q, acc_d;
  logic [BW-1:0]            beat_q, beat_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic                     err_q, err_d;
  logic [NUM_REQ-1:0]       grant;
  logic [IW-1:0]            gidx;
  logic                     beat;

  // Gating with reset keeps req_rdy low while reset is held, even though the FSM already sits in IDLE.
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i   (req_vld),
    .ptr_i   (ptr_q),
    .en_i    (state_q == IDLE && reset),
    .grant_o (grant),
    .idx_o   (gidx)
  );

  assign beat = eng_out_data_vld && (state_q == ISSUE || state_q == COLLECT);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    data_d  = data_q;
    poly_d  = poly_q;
    acc_d   = acc_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          state_d = ISSUE;
          id_d    = gidx;
          data_d  = req_data[int'(gidx)*IN_DATA_WIDTH +: IN_DATA_WIDTH];
          poly_d  = req_poly[int'(gidx)*4 +: 4];
          ptr_d   = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);
          acc_d   = '0;
          beat_d  = '0;
          tmo_d   = '0;
          err_d   = 1'b0;
        end
      end
      ISSUE, COLLECT: begin
        if (state_q == ISSUE) state_d = COLLECT;
        if (beat) begin
          acc_d  = acc_q + ACC_WIDTH'(eng_out_data);
          beat_d = beat_q + BW'(1);
          tmo_d  = '0;
          if (beat_d == BW'(SEG_COUNT)) begin
            state_d = RESP;
            err_d   = 1'b0;
          end
        end else if (state_q == COLLECT) begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TW'(TIMEOUT)) begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      RESP: state_d = rsp_rdy ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      poly_q  <= '0;
      acc_q   <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      data_q  <= data_d;
      poly_q  <= poly_d;
      acc_q   <= acc_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign req_rdy         = grant;
  assign eng_in_data_vld = state_q == ISSUE;
  assign eng_in_data     = data_q;
  assign eng_polynomial  = poly_q;
  assign rsp_vld         = state_q == RESP;
  assign rsp_id          = id_q;
  assign rsp_sum         = acc_q;
  assign rsp_err         = err_q;
  assign busy            = state_q != IDLE;

`ifdef CKSUM_ARB_STATS_EN
  logic [15:0] jobs_q;
  logic [7:0]  tmos_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      jobs_q <= '0;
      tmos_q <= '0;
    end else if (rsp_vld && rsp_rdy) begin
      jobs_q <= (&jobs_q) ? jobs_q : jobs_q + 16'd1;
      tmos_q <= (err_q && !(&tmos_q)) ? tmos_q + 8'd1 : tmos_q;
    end
  end

  assign stat_jobs     = jobs_q;
  assign stat_timeouts = tmos_q;
`endif

endmodule

// File: tb/tb_checksum_arbiter.sv
// tb_checksum_arbiter: scoreboard bench for checksum_arbiter with a scripted engine model.
module tb_checksum_arbiter;

  localparam int N   = 4;
  localparam int W   = 17;
  localparam int OW  = 21;
  localparam int SEG = 8;
  localparam int AW  = 24;
  localparam int TO  = 64;

  typedef struct {
    logic [1:0]    id;
    logic [AW-1:0] sum;
    logic          err;
  } rsp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_vld = '0;
  logic [N*W-1:0]  req_data;
  logic [N*4-1:0]  req_poly;
  logic [N-1:0]    req_rdy;
  logic            eng_in_data_vld;
  logic [W-1:0]    eng_in_data;
  logic [3:0]      eng_polynomial;
  logic [OW-1:0]   eng_out_data;
  logic            eng_out_data_vld;
  logic            rsp_vld;
  logic [1:0]      rsp_id;
  logic [AW-1:0]   rsp_sum;
  logic            rsp_err;
  logic            rsp_rdy = 1'b1;
  logic            busy;

  checksum_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .req_vld          (req_vld),
    .req_data         (req_data),
    .req_poly         (req_poly),
    .req_rdy          (req_rdy),
    .eng_in_data_vld  (eng_in_data_vld),
    .eng_in_data      (eng_in_data),
    .eng_polynomial   (eng_polynomial),
    .eng_out_data     (eng_out_data),
    .eng_out_data_vld (eng_out_data_vld),
    .rsp_vld          (rsp_vld),
    .rsp_id           (rsp_id),
    .rsp_sum          (rsp_sum),
    .rsp_err          (rsp_err),
    .rsp_rdy          (rsp_rdy),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  rsp_t exp_q[$];

  // Engine model: one idle cycle after the start pulse, then eng_n back-to-back beats of eng_val.
  int          eng_n = SEG;
  logic [OW-1:0] eng_val = '0;

  initial begin
    eng_out_data_vld = 1'b0;
    eng_out_data     = '0;
    forever begin
      @(negedge clk);
      if (eng_in_data_vld) begin
        @(negedge clk);
        for (int k = 0; k < eng_n; k++) begin
          @(negedge clk);
          eng_out_data_vld = 1'b1;
          eng_out_data     = eng_val;
        end
        @(negedge clk);
        eng_out_data_vld = 1'b0;
        eng_out_data     = '0;
      end
    end
  end

  int         cnt_rdy = 0;
  int         cnt_start = 0;
  int         grant_log[$];
  int         obs_g;
  logic [W-1:0] exp_data = '0;
  logic [3:0] exp_poly = '0;
  rsp_t       obs_e;

  always @(negedge clk) begin
    #2;
    if (|req_rdy) begin
      cnt_rdy++;
      for (int i = 0; i < N; i++) if (req_rdy[i]) obs_g = i;
      grant_log.push_back(obs_g);
      exp_data = req_data[obs_g*W +: W];
      exp_poly = req_poly[obs_g*4 +: 4];
    end
    if (eng_in_data_vld) begin
      cnt_start++;
      check("issue_data", 32'(eng_in_data), 32'(exp_data));
      check("issue_poly", 32'(eng_polynomial), 32'(exp_poly));
    end
    if (rsp_vld && rsp_rdy) begin
      check("rsp_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        obs_e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(obs_e.id));
        check("rsp_sum", 32'(rsp_sum), 32'(obs_e.sum));
        check("rsp_err", 32'(rsp_err), 32'(obs_e.err));
        check("hold_data", 32'(eng_in_data), 32'(exp_data));
      end
    end
  end

  task automatic do_job(input logic [N-1:0] mask, input int id, input int n, input logic [OW-1:0] val,
                        input logic [AW-1:0] sum, input logic err, input int hold);
    int   t0;
    int   k;
    rsp_t e;
    e.id  = 2'(id);
    e.sum = sum;
    e.err = err;
    exp_q.push_back(e);
    eng_n   = n;
    eng_val = val;
    rsp_rdy = (hold == 0);
    @(negedge clk);
    cnt_rdy   = 0;
    cnt_start = 0;
    req_vld   = mask;
    #1;
    check("grant", 32'(req_rdy), 32'(1) << id);
    t0 = cyc;
    @(negedge clk);
    req_vld = '0;
    k = 0;
    while (!rsp_vld && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("rsp_seen", 32'(rsp_vld), 1);
    check("latency", 32'(cyc - t0), err ? 32'(n + TO + 3) : 32'(SEG + 3));
    for (int i = 0; i < hold; i++) begin
      req_vld = N'(1 << ((id + 1) % N));
      #1;
      check("bp_vld", 32'(rsp_vld), 1);
      check("bp_sum", 32'(rsp_sum), 32'(sum));
      check("bp_rdy", 32'(req_rdy), 0);
      @(negedge clk);
    end
    req_vld = '0;
    rsp_rdy = 1'b1;
    @(negedge clk);
    #3;
    check("idle_after", 32'(busy), 0);
    check("rdy_pulses", 32'(cnt_rdy), 1);
    check("start_pulses", 32'(cnt_start), 1);
  endtask

  int exp_ord[5] = '{0, 1, 2, 3, 0};

  initial begin
    int k;
    req_data = {17'h0F0F3, 17'h1ABCD, 17'h05551, 17'h00AA0};
    req_poly = {4'h9, 4'h5, 4'h3, 4'h1};
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", 32'({busy, rsp_vld, eng_in_data_vld, rsp_err, req_rdy, rsp_id}), 0);
    check("rst_sum", 32'(rsp_sum), 0);
    check("rst_eng", 32'({eng_polynomial, eng_in_data}), 0);
    reset = 1'b1;

    // Round-robin with all requesters held valid.
    eng_n   = SEG;
    eng_val = 21'h1;
    for (int i = 0; i < 5; i++) begin
      rsp_t e;
      e.id  = 2'(exp_ord[i]);
      e.sum = 24'h8;
      e.err = 1'b0;
      exp_q.push_back(e);
    end
    grant_log.delete();
    @(negedge clk);
    req_vld = 4'hF;
    k = 0;
    while (grant_log.size() < 5 && k < 500) begin
      @(negedge clk);
      k++;
    end
    req_vld = '0;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("rr_count", 32'(grant_log.size()), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) check("rr_order", 32'(grant_log[i]), 32'(exp_ord[i]));
    check("rr_drain", 32'(exp_q.size()), 0);

    do_job(4'b0100, 2, SEG, 21'h00010, 24'h000080, 1'b0, 0);
    do_job(4'b0010, 1, SEG, 21'h1FFFFF, 24'hFFFFF8, 1'b0, 0);
    do_job(4'b1000, 3, 3, 21'h7, 24'h000015, 1'b1, 0);
    do_job(4'b0001, 0, SEG + 5, 21'h3, 24'h000018, 1'b0, 10);

    // Reset in the middle of collection: no response, pointer back to 0.
    eng_n   = SEG;
    eng_val = 21'h1;
    rsp_rdy = 1'b1;
    @(negedge clk);
    req_vld = 4'b1000;
    @(negedge clk);
    req_vld = '0;
    repeat (4) @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    check("mrst_ctrl", 32'({busy, rsp_vld, eng_in_data_vld, rsp_err, req_rdy, rsp_id}), 0);
    check("mrst_sum", 32'(rsp_sum), 0);
    check("mrst_eng", 32'({eng_polynomial, eng_in_data}), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_idle", 32'(busy), 0);
    do_job(4'hF, 0, SEG, 21'h2, 24'h000010, 1'b0, 0);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/checksum_arbiter.md
Name: checksum_arbiter

Overview:
- Shares one checksum engine between NUM_REQ requesters using round-robin arbitration.
- For each job: captures the winner's data word and polynomial, issues one start pulse to the engine, then collects SEG_COUNT result beats and sums them into an ACC_WIDTH total.
- Returns the total with the requester ID through a valid/ready response port.
- Sits between the packet-side requesters and the checksum engine; the block is the engine's only driver.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- IN_DATA_WIDTH, 17, engine input word width
- OUT_DATA_WIDTH, 21, engine result beat width
- SEG_COUNT, 8, result beats per job
- ACC_WIDTH, 24, response sum width (>= OUT_DATA_WIDTH)
- TIMEOUT, 64, maximum idle cycles between beats while collecting

Ports:
- clk, in, 1: single clock.
- reset, in, 1: asynchronous active-low reset.
- req_vld, in, NUM_REQ: per-requester job request.
- req_data, in, NUM_REQ*IN_DATA_WIDTH: packed data words; requester i occupies slice [i*IN_DATA_WIDTH +: IN_DATA_WIDTH].
- req_poly, in, NUM_REQ*4: packed polynomials; requester i occupies [i*4 +: 4].
- req_rdy, out, NUM_REQ: one-hot accept; transfer occurs when req_vld[i]&req_rdy[i] at a clk edge.
- eng_in_data_vld, out, 1: engine start pulse.
- eng_in_data, out, IN_DATA_WIDTH: job word to engine.
- eng_polynomial, out, 4: job polynomial to engine.
- eng_out_data, in, OUT_DATA_WIDTH: engine result beat.
- eng_out_data_vld, in, 1: engine beat valid.
- rsp_vld, out, 1: response valid.
- rsp_id, out, $clog2(NUM_REQ): requester index of the completed job.
- rsp_sum, out, ACC_WIDTH: accumulated sum.
- rsp_err, out, 1: job ended by timeout.
- rsp_rdy, in, 1: response accept.
- busy, out, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE and the round-robin pointer is set to 0.
  - All outputs are 0, including eng_in_data and eng_polynomial.
  - Accumulator, beat counter and timeout counter are cleared.
- Reset asserted mid-job aborts the job with no response. Engine beats arriving after reset release while in IDLE are ignored.
- IDLE:
  - If any req_vld bit is set, grant the first set bit at or above the pointer, wrapping. req_rdy[g] is combinational in this cycle.
  - At the edge: latch the data and polynomial slices and g, set pointer = g+1 mod NUM_REQ, clear accumulator and counters, go to ISSUE.
  - If no request is pending, remain in IDLE.
- ISSUE (1 cycle): eng_in_data_vld=1, then go to COLLECT.
- Hold rule: eng_in_data and eng_polynomial are driven from the job registers and stay stable from ISSUE until the next grant, because the engine re-samples its input every cycle.
- COLLECT:
  - Each eng_out_data_vld cycle: acc += zero-extended eng_out_data (modulo 2^ACC_WIDTH), beat_cnt++, timeout counter cleared.
  - On the SEG_COUNT-th beat, go to RESP with rsp_err=0; that beat is included in the sum.
  - Each cycle without a beat increments the timeout counter. When it reaches TIMEOUT, go to RESP with rsp_err=1 and the partial sum.
  - Beats arriving in the ISSUE cycle count as valid collection beats.
- RESP:
  - rsp_vld=1; rsp_id, rsp_sum and rsp_err are held stable.
  - When rsp_rdy=1, go to IDLE at the edge.
  - No new grant is issued in the same cycle as the response handshake. Minimum job-to-job spacing is therefore ISSUE + SEG_COUNT beats + RESP + IDLE.
  - Engine beats arriving in RESP or IDLE are discarded.
- A requester may drop req_vld before being granted with no effect. A request is never granted twice for one handshake.
- Polynomial 0 needs no special case: the engine returns zero beats and the sum is 0.
- Latency with the engine streaming back-to-back and rsp_rdy tied high: req_vld to rsp_vld is SEG_COUNT+3 cycles.

Optional Feature:
- Macro CKSUM_ARB_STATS_EN.
- When defined, the block adds output stat_jobs[15:0] and output stat_timeouts[7:0]:
  - stat_jobs increments on each response handshake.
  - stat_timeouts increments on each handshake with rsp_err=1.
  - Both counters saturate and are cleared by reset.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cksum_arb_pkg holds:
  - the FSM state encoding (IDLE, ISSUE, COLLECT, RESP);
  - default parameter constants;
  - the function id_width(n) = $clog2(n) with a minimum of 1.
- One sub-module, rr_arbiter (parameter N): inputs req, pointer and enable; outputs one-hot grant and encoded index; purely combinational.
- The FSM, counters and accumulator live in checksum_arbiter.

Test Plan:
- Single job: req_vld[2]=1, data 0x1ABCD, poly 4'h5; engine returns 8 beats of 0x00010 → req_rdy[2] pulses once, eng_in_data_vld is one cycle, rsp_id=2, rsp_sum=0x80, rsp_err=0.
- Round-robin: all four requesters held valid → grant order 0,1,2,3,0; after grant to 3, requester 0 wins next.
- Wrap: 8 beats of 0x1FFFFF with ACC_WIDTH=24 → rsp_sum=0xFFFFF8, no saturation.
- Timeout: engine returns 3 beats of 0x7, then none → after 64 idle cycles rsp_vld=1, rsp_err=1, rsp_sum=0x15.
- Backpressure and stray beats: rsp_rdy low for 10 cycles while extra beats arrive → rsp_sum unchanged, no new grant, req_rdy stays 0.
- Mid-job reset: reset pulsed low during COLLECT → all outputs 0 immediately, no response; next request is granted to requester 0 first.
